// File: rtl/wb_buf_resp.sv
// wb_buf_resp: Wishbone responder serving a 2^AW x 64-bit buffer.
// Single and linear-burst transfers, programmable first-beat wait, err counter.
module wb_buf_resp #(
  parameter int unsigned AW   = 6,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned WAIT = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cab_i,
  input  logic        wbs_pref_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_dat64_i,
  input  logic        lock_i,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] wbs_dat64_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned DEPTH  = 1 << AW;
  localparam logic [3:0]  WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_REC
  } state_e;

  state_e state_q, state_d;

  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic          burst_q, burst_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   dat64_q, dat64_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [63:0]   mem_q [DEPTH];

  logic          req;
  logic          in_win;
  logic          sel_ok;
  logic [AW-1:0] adr_idx;
  logic          go_ack;
  logic          go_err;
  logic          go_rty;
  logic [AW-1:0] ack_idx;
  logic          ack_we;
  logic          mem_we;
  logic          unused_ok;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign in_win    = wbs_adr_i[31:AW+3] == BASE[31:AW+3];
  assign sel_ok    = wbs_sel_i == 4'hF;
  assign adr_idx   = wbs_adr_i[AW+2:3];
  assign unused_ok = ^wbs_adr_i[2:0];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      dat_q     <= '0;
      dat64_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      burst_q   <= burst_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      dat_q     <= dat_d;
      dat64_q   <= dat64_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Buffer contents survive reset; only the handshake state is cleared.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      mem_q[ack_idx] <= {wbs_dat64_i, wbs_dat_i};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    burst_d = burst_q;
    go_ack  = 1'b0;
    go_err  = 1'b0;
    go_rty  = 1'b0;
    ack_idx = idx_q;
    ack_we  = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (lock_i) begin
            go_rty  = 1'b1;
            state_d = S_REC;
          end else if (!in_win || !sel_ok) begin
            go_err  = 1'b1;
            state_d = S_REC;
          end else begin
            idx_d   = adr_idx;
            we_d    = wbs_we_i;
            burst_d = wbs_cab_i & (wbs_we_i | wbs_pref_i);
            cnt_d   = WAIT_C;
            if (WAIT_C == 4'd0) begin
              go_ack  = 1'b1;
              ack_idx = adr_idx;
              ack_we  = wbs_we_i;
              state_d = S_BEAT;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            go_ack  = 1'b1;
            state_d = S_BEAT;
          end
        end
      end
      S_BEAT: begin
        if (burst_q && req && wbs_cab_i) begin
          go_ack  = 1'b1;
          idx_d   = idx_q + 1'b1;
          ack_idx = idx_q + 1'b1;
        end else begin
          state_d = S_REC;
        end
      end
      S_REC: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ack_d     = go_ack;
    err_d     = go_err;
    rty_d     = go_rty;
    dat_d     = dat_q;
    dat64_d   = dat64_q;
    err_cnt_d = err_cnt_q;
    mem_we    = go_ack & ack_we & ~wb_rst_i;
    if (go_ack && !ack_we) begin
      {dat64_d, dat_d} = mem_q[ack_idx];
    end
    if (go_err && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_rty_o   = rty_q;
  assign wbs_dat_o   = dat_q;
  assign wbs_dat64_o = dat64_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wb_buf_resp.sv
// tb_wb_buf_resp: scoreboard bench for wb_buf_resp.
// Master tasks push expected terminations; a monitor pops and compares.
module tb_wb_buf_resp;

  localparam int AW = 3;
  localparam int WT = 3;
  localparam int N  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, cab, pref, lock;
  logic [3:0]  sel;
  logic [31:0] adr, dat, dat64;
  logic [31:0] dat_o, dat64_o;
  logic        ack, err, rty;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  wb_buf_resp #(
    .AW  (AW),
    .BASE(32'h0000_0000),
    .WAIT(WT)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_cab_i  (cab),
    .wbs_pref_i (pref),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_dat64_i(dat64),
    .lock_i     (lock),
    .wbs_dat_o  (dat_o),
    .wbs_dat64_o(dat64_o),
    .wbs_ack_o  (ack),
    .wbs_err_o  (err),
    .wbs_rty_o  (rty),
    .err_cnt_o  (err_cnt)
  );

  typedef struct {
    logic [2:0]  kind;
    bit          chk;
    logic [63:0] data;
  } exp_t;

  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  exp_t        exp_q[$];
  logic [63:0] mm [N];
  logic [63:0] wdata [8];
  int          model_err;
  int          total;
  int          bad;
  bit          mon_en;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (mon_en && !rst && (ack || err || rty)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'({ack, err, rty}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", 64'({ack, err, rty}), 64'(e.kind));
        if (e.chk) check("rd_data", {dat64_o, dat_o}, e.data);
      end
    end
  end

  task automatic push(input logic [2:0] k, input bit c, input logic [63:0] d);
    exp_t e;
    e.kind = k;
    e.chk  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    cyc = 0; stb = 0; we = 0; cab = 0; pref = 0; lock = 0;
    sel = 4'hF; adr = '0; dat = '0; dat64 = '0;
  endtask

  // Reference: lock wins, then window/sel errors, else n or 1 beats.
  task automatic xfer(input logic w, input logic c, input logic p,
                      input logic [3:0] s, input logic [31:0] a,
                      input int n, input logic lk);
    int idx, neff, lat, acks, i;
    bit done, first;
    idx = int'(a[AW+2:3]);
    lat = 1;
    if (lk) begin
      push(K_RTY, 0, '0);
    end else if (a[31:AW+3] != '0 || s != 4'hF) begin
      push(K_ERR, 0, '0);
      model_err = (model_err < 255) ? model_err + 1 : 255;
    end else begin
      lat  = WT + 1;
      neff = (c && (w || p)) ? n : 1;
      for (int k = 0; k < neff; k++) begin
        i = (idx + k) % N;
        if (w) begin
          mm[i] = wdata[k];
          push(K_ACK, 0, '0);
        end else begin
          push(K_ACK, 1, mm[i]);
        end
      end
    end
    @(negedge clk);
    cyc = 1; stb = 1; we = w; cab = c; pref = p;
    sel = s; adr = a; lock = lk;
    {dat64, dat} = wdata[0];
    acks = 0; done = 0; first = 1;
    for (int t = 1; t <= 40 && !done; t++) begin
      @(negedge clk);
      if (first && (ack || err || rty)) begin
        first = 0;
        check("latency", 64'(t), 64'(lat));
      end
      if (err || rty) done = 1;
      else if (ack) begin
        acks++;
        if (acks == n) done = 1;
        else {dat64, dat} = wdata[acks];
      end else if (acks > 0) done = 1;
    end
    check("timeout", 64'(done), 64'd1);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("resp_left", 64'(exp_q.size()), 64'd0);
    check("err_cnt", 64'(err_cnt), 64'(model_err));
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    total = 0; bad = 0; model_err = 0; mon_en = 1;
    drive_idle();
    rst = 1;
    #12;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rty", 64'(rty), 64'd0);
    check("rst_dat", {dat64_o, dat_o}, 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
    xfer(1, 1, 0, 4'hF, 32'h0, 8, 0);

    wdata[0] = 64'h5A5A_0002_A5A5_0001;
    xfer(1, 0, 0, 4'hF, 32'h10, 1, 0);
    xfer(0, 0, 0, 4'hF, 32'h10, 1, 0);

    for (int k = 0; k < 4; k++) wdata[k] = 64'h1111_0000_0000_0000 * (k + 1) + 64'(k);
    xfer(1, 1, 0, 4'hF, 32'h38, 4, 0);
    xfer(0, 1, 1, 4'hF, 32'h38, 4, 0);
    xfer(0, 1, 0, 4'hF, 32'h38, 4, 0);

    xfer(0, 0, 0, 4'hF, 32'h8000_0000, 1, 0);
    xfer(1, 0, 0, 4'b0011, 32'h8, 1, 0);
    check("err_cnt_two", 64'(err_cnt), 64'd2);

    xfer(0, 0, 0, 4'hF, 32'h8000_0000, 1, 1);
    xfer(0, 0, 0, 4'hF, 32'h18, 1, 0);

    // Abort: req dropped after one wait cycle, word 5 must be untouched.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h28;
    {dat64, dat} = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("abort_quiet", 64'({ack, err, rty}), 64'd0);
    end
    xfer(0, 0, 0, 4'hF, 32'h28, 1, 0);

    for (int r = 0; r < 80; r++) begin
      for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
      a = 32'((($urandom % N) << 3) | ($urandom % 8));
      if ($urandom % 10 == 0) a = a | 32'h8000_0000;
      xfer($urandom % 2 == 1, $urandom % 2 == 1, $urandom % 2 == 1,
           ($urandom % 10 == 0) ? 4'b0011 : 4'hF, a,
           1 + int'($urandom % 4), $urandom % 12 == 0);
    end

    for (int r = 0; r < 300; r++) xfer(0, 0, 0, 4'hF, 32'h8000_0000, 1, 0);
    check("err_sat", 64'(err_cnt), 64'd255);

    // Reset during a burst read.
    mon_en = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; cab = 1; pref = 1; sel = 4'hF; adr = 32'h0;
    acks = 0;
    for (int t = 0; t < 20 && acks < 2; t++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("burst_started", 64'(acks), 64'd2);
    rst = 1;
    #1;
    check("mid_rst_ack", 64'(ack), 64'd0);
    check("mid_rst_errrty", 64'({err, rty}), 64'd0);
    check("mid_rst_dat", {dat64_o, dat_o}, 64'd0);
    check("mid_rst_errcnt", 64'(err_cnt), 64'd0);
    drive_idle();
    @(negedge clk);
    rst = 0;
    model_err = 0;
    exp_q.delete();
    mon_en = 1;
    xfer(0, 1, 1, 4'hF, 32'h30, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_buf_resp.md
Name: wb_buf_resp

Overview:
- Wishbone responder (slave) that terminates the shared master bus driven by the channel mixer.
- Decodes an address window and serves single and linear-burst (cab) reads and writes against an internal 2^AW x 64-bit buffer. The low half travels on dat, the high half on dat64.
- Generates ack/err/rty with a programmable first-beat wait and keeps a saturating error counter for debug.

Parameters:
- AW, 6, buffer index width (2^AW 64-bit words).
- BASE, 32'h0000_0000, window base; bits [31:AW+3] are compared, lower bits are ignored.
- WAIT, 1, extra wait cycles before the first ack of a transfer (0..15).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1=write, 0=read
- wbs_cab_i  in  1  consecutive-address burst
- wbs_pref_i  in  1  prefetch permit; burst reads are honoured only when 1
- wbs_sel_i  in  4  byte select; only 4'b1111 is legal
- wbs_adr_i  in  32  byte address; [2:0] ignored; index = [AW+2:3]
- wbs_dat_i  in  32  write data, low word
- wbs_dat64_i  in  32  write data, high word
- lock_i  in  1  buffer locked by the owner; requests get rty
- wbs_dat_o  out  32  read data, low word
- wbs_dat64_o  out  32  read data, high word
- wbs_ack_o  out  1  normal termination
- wbs_err_o  out  1  error termination
- wbs_rty_o  out  1  retry termination
- err_cnt_o  out  8  saturating count of err pulses

Behaviour:
- Reset (asynchronous, also mid-transfer):
  - ack/err/rty=0, dat/dat64=0, err_cnt=0, FSM=IDLE, burst address=0.
  - Buffer contents are not reset.
  - An in-flight write is lost.
- All outputs are registered.
- "req" means cyc&stb.
- FSM states: IDLE, WAIT, BEAT, REC.
- IDLE, on req, checks in priority order:
  - lock_i=1 -> rty pulse next cycle -> REC.
  - Address outside window, or sel!=4'b1111 -> err pulse next cycle, err_cnt+1 (saturates at 255) -> REC.
  - Otherwise: latch adr index, we, and burst = cab & (we | pref); load wait counter with WAIT -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0: ack=1 next cycle; read data for the latched index is valid in the same cycle as ack -> BEAT.
  - First-ack latency = WAIT+1 cycles after the IDLE cycle that saw req.
  - If req drops in WAIT: abort, no termination, no write -> IDLE.
- Write commit: {dat64_i, dat_i} sampled at the edge where ack is asserted. Data must be held stable by the master from the req cycle.
- BEAT, single (burst=0): ack lasts exactly 1 cycle -> REC.
- BEAT, burst=1: while req & cab remain high, ack is held every cycle.
  - Index increments per beat; the next beat's read data is presented with its ack.
  - Writes commit on each ack edge with the current dat inputs.
  - Index wraps modulo 2^AW inside the window (no err on wrap).
  - req or cab low -> ack drops in the same registered cycle; the beat presented in that cycle is not counted -> REC.
- REC: one cycle; req is ignored there so a registered master can drop stb -> IDLE.
- Back-to-back single transfers therefore cost WAIT+3 cycles each.
- err and rty are never asserted together with ack. Each is exactly one cycle.
- we is captured at the start of a transfer; a change of we mid-burst is ignored.
- Read data outputs hold their last value when ack is low.

Test Plan:
- Single write then read, WAIT=1, BASE=0:
  - Write adr=0x10, dat=0xA5A5_0001, dat64=0x5A5A_0002 -> ack 2 cycles after req.
  - Read adr=0x10 -> ack with dat=0xA5A5_0001, dat64=0x5A5A_0002.
- Burst write with cab=1, 4 beats from adr=0x38 (index 7), AW=3:
  - Indices 7,0,1,2 written (wrap).
  - Burst read with pref=1 returns the same 4 words with ack held 4 consecutive cycles.
- Burst read with cab=1, pref=0 -> single ack only, then 1 REC cycle; the master sees ack low on the second beat.
- Out-of-window adr=0x8000_0000 and, separately, sel=4'b0011:
  - Each gives an err pulse 1 cycle after req, no ack.
  - err_cnt_o=2.
  - 300 such errors -> err_cnt_o saturates at 255.
- lock_i=1 together with an out-of-window request -> rty only (err_cnt unchanged); lock_i=0 retry succeeds.
- Abort and reset cases:
  - WAIT=3: drop cyc after 1 WAIT cycle -> no termination, buffer word unchanged.
  - Assert wb_rst_i mid-burst -> all outputs 0 immediately; next request serviced normally.
